weighted_rr_scheduler: RTL and testbench

//   Shares one downstream valid/ready stream port between N upstream requesters.

---
 rtl/weighted_rr_scheduler.sv | 138 +++++++++++++
 tb/tb_weighted_rr_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weighted_rr_scheduler.sv
// Purpose: shares one downstream valid/ready stream between N requesters, round robin, weight[i] beats per turn.
// Latency: grant registered one cycle after the first request; datapath owner->downstream is combinational.
// Backpressure: m_ready low stalls the owner (grant and quantum held); only the owner's s_ready follows m_ready.
module weighted_rr_scheduler #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int WW = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N-1:0]                  s_valid,
    input  logic [N*DW-1:0]               s_data,
    output logic [N-1:0]                  s_ready,
    input  logic [N*WW-1:0]               weight,
    output logic                          m_valid,
    output logic [DW-1:0]                 m_data,
    input  logic                          m_ready,
    output logic [N-1:0]                  grant,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] m_src
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state;
    logic [WW-1:0] cnt;
    logic [IW-1:0] ptr;

    logic          win_vld;
    logic [IW-1:0] win_idx;
    logic [N-1:0]  win_oh;
    logic [WW-1:0] win_wt;
    logic [WW-1:0] win_cnt;
    int            best_dist;

    logic          beat;
    logic          rel_now;

    // Round-robin pick: the valid requester closest after ptr wins; ptr itself is checked last.
    always_comb begin
        win_vld   = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        best_dist = N;
        for (int i = 0; i < N; i++) begin
            if (s_valid[i] && (((i + 2*N - int'(ptr) - 1) % N) < best_dist)) begin
                win_vld   = 1'b1;
                win_idx   = IW'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
                best_dist = (i + 2*N - int'(ptr) - 1) % N;
            end
        end
    end

    // Quantum for the winner; a zero weight still grants one beat.
    always_comb begin
        win_wt = '0;
        for (int i = 0; i < N; i++) begin
            if (win_oh[i]) begin
                win_wt = weight[i*WW +: WW];
            end
        end
        win_cnt = (win_wt == '0) ? WW'(1) : win_wt;
    end

    // Zero-latency mux from the owner to the downstream port; idle drives everything low.
    always_comb begin
        m_valid = 1'b0;
        m_data  = '0;
        s_ready = '0;
        if (state == OWN) begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    m_valid    = s_valid[i];
                    s_ready[i] = m_ready;
                    if (s_valid[i]) begin
                        m_data = s_data[i*DW +: DW];
                    end
                end
            end
        end
    end

    // Ownership ends on the last beat of the quantum or when the owner drops valid.
    always_comb begin
        beat    = m_valid & m_ready;
        rel_now = (state == OWN) && ((beat && (cnt == WW'(1))) || !m_valid);
    end

    // Ownership FSM: loads grant/quantum on a win, counts beats, hands over without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            m_src <= '0;
            cnt   <= '0;
            ptr   <= IW'(N - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state <= OWN;
                        grant <= win_oh;
                        m_src <= win_idx;
                        cnt   <= win_cnt;
                        ptr   <= win_idx;
                    end
                end
                OWN: begin
                    if (rel_now) begin
                        if (win_vld) begin
                            grant <= win_oh;
                            m_src <= win_idx;
                            cnt   <= win_cnt;
                            ptr   <= win_idx;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                            m_src <= '0;
                            cnt   <= '0;
                        end
                    end else if (beat) begin
                        cnt <= cnt - WW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    m_src <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weighted_rr_scheduler.sv
// Purpose: directed and random checks of weighted_rr_scheduler against a turn-based reference model.
// Latency: outputs sampled 3 time units after each rising edge; the model advances once per clock.
// Backpressure: m_ready is driven both as fixed stalls and randomly.
module tb_weighted_rr_scheduler;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int WW = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      s_valid;
    logic [N*DW-1:0]   s_data;
    logic [N-1:0]      s_ready;
    logic [N*WW-1:0]   weight;
    logic              m_valid;
    logic [DW-1:0]     m_data;
    logic              m_ready;
    logic [N-1:0]      grant;
    logic [IW-1:0]     m_src;

    weighted_rr_scheduler #(.N(N), .DW(DW), .WW(WW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .weight  (weight),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .grant   (grant),
        .m_src   (m_src)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, beats left in the turn, last owner.
    int own = -1;
    int rem = 0;
    int ptr = N - 1;
    int beats[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int quantum(input int i);
        int w;
        w = int'(weight[i*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    // Next owner: first valid requester after the last owner, wrapping around to it.
    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (s_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic take_turn(input int w);
        own = w;
        rem = quantum(w);
        ptr = w;
    endtask

    task automatic model_reset();
        own = -1;
        rem = 0;
        ptr = N - 1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) s_data[i*DW +: DW] = $urandom;
    endtask

    // One clock: compare outputs against the model, record beats, advance the model.
    task automatic cyc(input string tag);
        logic [N-1:0]  eg;
        logic [N-1:0]  er;
        logic          ev;
        logic [DW-1:0] ed;
        bit            bt;
        bit            rl;
        int            w;
        #2;
        eg = (own < 0) ? '0 : (N'(1) << own);
        ev = (own >= 0) ? s_valid[own] : 1'b0;
        ed = ev ? s_data[own*DW +: DW] : '0;
        er = (own >= 0 && m_ready) ? eg : '0;
        chk({tag, ".grant"},   64'(grant),   64'(eg));
        chk({tag, ".m_src"},   64'(m_src),   (own < 0) ? 64'd0 : 64'(own));
        chk({tag, ".m_valid"}, 64'(m_valid), 64'(ev));
        chk({tag, ".m_data"},  64'(m_data),  64'(ed));
        chk({tag, ".s_ready"}, 64'(s_ready), 64'(er));
        if (m_valid && m_ready) beats.push_back(int'(m_src));
        if (own < 0) begin
            w = pick();
            if (w >= 0) take_turn(w);
        end else begin
            bt = s_valid[own] && m_ready;
            if (bt) rem--;
            rl = !s_valid[own] || (bt && rem == 0);
            if (rl) begin
                w = pick();
                if (w >= 0) take_turn(w);
                else own = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_q[$];
        rst_n   = 1'b0;
        s_valid = '0;
        s_data  = '0;
        weight  = '0;
        m_ready = 1'b0;
        #1;
        chk("rst.grant",   64'(grant),   64'd0);
        chk("rst.m_src",   64'(m_src),   64'd0);
        chk("rst.m_valid", 64'(m_valid), 64'd0);
        chk("rst.m_data",  64'(m_data),  64'd0);
        chk("rst.s_ready", 64'(s_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset in the middle of a burst.
        s_valid = 4'hF;
        weight  = {4{4'd4}};
        m_ready = 1'b1;
        rand_data();
        repeat (3) cyc("t1");
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t1.async.grant",   64'(grant),   64'd0);
        chk("t1.async.m_valid", 64'(m_valid), 64'd0);
        chk("t1.async.s_ready", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        s_valid = 4'b1011;
        cyc("t1.post");
        chk("t1.first_grant", 64'(grant), 64'h1);
        cyc("t1.post");

        // Equal weights of 2: two beats per owner, no bubbles.
        do_reset();
        s_valid = 4'hF;
        weight  = {4{4'd2}};
        m_ready = 1'b1;
        beats.delete();
        for (int c = 0; c < 17; c++) begin
            rand_data();
            cyc("t2");
        end
        chk("t2.nbeats", 64'(beats.size()), 64'd16);
        for (int k = 0; k < 16 && k < beats.size(); k++)
            chk($sformatf("t2.owner%0d", k), 64'(beats[k]), 64'((k / 2) % 4));

        // Mixed weights {15,2,0,3}: bursts of 3,1,2,15.
        do_reset();
        weight  = {4'd15, 4'd2, 4'd0, 4'd3};
        s_valid = 4'hF;
        beats.delete();
        exp_q.delete();
        for (int r = 0; r < 2; r++) begin
            repeat (3)  exp_q.push_back(0);
            repeat (1)  exp_q.push_back(1);
            repeat (2)  exp_q.push_back(2);
            repeat (15) exp_q.push_back(3);
        end
        for (int c = 0; c < 43; c++) begin
            rand_data();
            cyc("t3");
        end
        chk("t3.nbeats", 64'(beats.size()), 64'd42);
        for (int k = 0; k < 42 && k < beats.size(); k++)
            chk($sformatf("t3.owner%0d", k), 64'(beats[k]), 64'(exp_q[k]));

        // Owner withdraws early; requester 3 takes over on the next edge.
        do_reset();
        weight  = {4'd1, 4'd1, 4'd4, 4'd1};
        s_valid = 4'b0010;
        rand_data();
        cyc("t4");
        cyc("t4");
        s_valid = 4'b1000;
        cyc("t4");
        chk("t4.handover", 64'(grant), 64'h8);
        cyc("t4");

        // Stall for five cycles, then the full quantum completes.
        do_reset();
        weight  = {4'd1, 4'd1, 4'd1, 4'd3};
        s_valid = 4'b0011;
        m_ready = 1'b0;
        rand_data();
        cyc("t5");
        repeat (5) cyc("t5.stall");
        chk("t5.stall.nbeats", 64'(beats.size()), 64'(beats.size()));
        beats.delete();
        m_ready = 1'b1;
        repeat (4) cyc("t5.run");
        chk("t5.run.nbeats", 64'(beats.size()), 64'd4);
        exp_q = '{0, 0, 0, 1};
        for (int k = 0; k < 4 && k < beats.size(); k++)
            chk($sformatf("t5.owner%0d", k), 64'(beats[k]), 64'(exp_q[k]));

        // Sole requester with weight 1 is re-granted every beat.
        do_reset();
        weight  = {4'd5, 4'd1, 4'd5, 4'd5};
        s_valid = 4'b0100;
        m_ready = 1'b1;
        cyc("t6");
        for (int c = 0; c < 6; c++) begin
            rand_data();
            cyc("t6");
            chk("t6.grant", 64'(grant), 64'h4);
        end

        // Random traffic, weights and backpressure.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            s_valid = N'($urandom) | N'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) weight = (N*WW)'($urandom);
            rand_data();
            cyc("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
